uart_receiver: RTL and testbench

Serial-to-parallel UART receiver (8 data bits, 1 stop bit, LSB first) for the tiny RISC-V board top. It samples the board's `i_UART_RX` pin on the internal clock and presents each completed byte as a one-cycle valid pulse. It also flags framing errors. It is the receive-side counterpart of the board's UART transmit path, and it feeds the processor's memory-mapped I/O.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_receiver.sv | 136 +++++++++++++
 tb/tb_uart_receiver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared package: frame constants and FSM state encodings
// used by both the receive and transmit paths.
package uart_pkg;

  localparam int c_DATA_BITS = 8;
  localparam int c_CLKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

  function automatic logic even_parity(
    input logic [c_DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs
// (serial lines, switches); synchronous active-high reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 LSB first; 8E1 with o_Parity_Err when
// UART_RX_PARITY_EN is defined.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int c_CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Frame_Err,
`ifdef UART_RX_PARITY_EN
  output logic       o_Parity_Err,
`endif
  output logic       o_Busy
);

  localparam int CW = $clog2(c_CLKS_PER_BIT);
  localparam logic [CW-1:0] c_MID  = CW'((c_CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] c_LAST = CW'(c_CLKS_PER_BIT - 1);

  uart_state_t              state;
  logic [CW-1:0]            cnt;
  logic [2:0]               idx;
  logic [c_DATA_BITS-1:0]   data;
  logic                     armed;
  logic                     rx_s;
  logic                     start_det;
`ifdef UART_RX_PARITY_EN
  logic                     par_bad;
`endif

  // Reset low so a line held low through reset never looks idle.
  sync_2ff #(
    .RST_VAL (1'b0)
  ) u_sync (
    .clk (i_Clk),
    .rst (i_Rst),
    .d   (i_RX_Serial),
    .q   (rx_s)
  );

  assign start_det = (state == ST_IDLE) && armed && !rx_s;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      data         <= '0;
      armed        <= 1'b0;
      o_RX_DV      <= 1'b0;
      o_RX_Byte    <= '0;
      o_Frame_Err  <= 1'b0;
      o_Busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      o_Parity_Err <= 1'b0;
`endif
    end else begin
      o_RX_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_Parity_Err <= 1'b0;
`endif
      armed  <= armed | rx_s;
      // Lags the state by one cycle but rises with the start edge,
      // so back-to-back frames show at most one idle cycle.
      o_Busy <= (state != ST_IDLE) || start_det;
      cnt    <= cnt + CW'(1);
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start_det) state <= ST_START;
        end
        ST_START: begin
          if (cnt == c_MID) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (cnt == c_LAST) begin
            cnt       <= '0;
            data[idx] <= rx_s;
            idx       <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
        ST_PARITY: begin
          if (cnt == c_LAST) begin
            cnt   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= (rx_s != even_parity(data));
`endif
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt == c_LAST) begin
            cnt <= '0;
`ifdef UART_RX_PARITY_EN
            o_Parity_Err <= par_bad;
`endif
            if (rx_s) begin
              o_RX_Byte <= data;
              o_RX_DV   <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              o_Frame_Err <= 1'b1;
              state       <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= ST_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of frames plus
// hand sequences, with a scoreboard queue of expected pulses.
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
  localparam int CPB = 217;
  localparam bit PAR = 1'b1;
`else
  localparam int CPB = 4;
  localparam bit PAR = 1'b0;
`endif
  localparam int H   = (CPB - 1) / 2;
  localparam int LAT = 4 + H + 9 * CPB + (PAR ? CPB : 0);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       dv;
  logic [7:0] rx_byte;
  logic       fe;
  logic       busy;
  logic       pe;

  uart_receiver #(
    .c_CLKS_PER_BIT (CPB)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_RX_Serial  (rx),
    .o_RX_DV      (dv),
    .o_RX_Byte    (rx_byte),
    .o_Frame_Err  (fe),
`ifdef UART_RX_PARITY_EN
    .o_Parity_Err (pe),
`endif
    .o_Busy       (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign pe = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic       dv;
    logic       fe;
    logic       pe;
    int         at;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       flip;
    int         hold;
    int         gap;
  } vec_t;

  exp_t       q[$];
  exp_t       got;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;

  bit watch = 1'b0;
  bit seen_high = 1'b0;
  int run = 0;
  int maxrun = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(logic [7:0] d, logic stop, logic flip, int hold);
    exp_t e;
    logic p;
    p    = (^d) ^ flip;
    rx   = 1'b0;
    e.at = cyc + LAT;
    e.dv = stop;
    e.fe = !stop;
    e.pe = PAR && flip;
    if (stop) last_good = d;
    e.b  = last_good;
    q.push_back(e);
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(CPB);
    end
    if (PAR) begin
      rx = p;
      wait_cyc(CPB);
    end
    rx = stop;
    wait_cyc(CPB);
    if (hold > 0) begin
      rx = 1'b0;
      wait_cyc(hold);
    end
  endtask

  always @(negedge clk) begin
    if (dv || fe || pe) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse dv=%0b fe=%0b pe=%0b cyc=%0d",
                 dv, fe, pe, cyc);
      end else begin
        got = q.pop_front();
        chk("dv", dv, got.dv);
        chk("frame_err", fe, got.fe);
        chk("parity_err", pe, got.pe);
        chk("byte", rx_byte, got.b);
        chk("pulse_cycle", cyc, got.at);
      end
    end
  end

  always @(negedge clk) begin
    if (watch) begin
      if (busy) begin
        if (seen_high && run > maxrun) maxrun = run;
        seen_high = 1'b1;
        run = 0;
      end else begin
        run++;
      end
    end
  end

  vec_t vecs[5];
  int   k;

  initial begin
    vecs[0] = '{d: 8'hA5, stop: 1'b1, flip: 1'b0, hold: 0,  gap: 5};
    vecs[1] = '{d: 8'h3C, stop: 1'b0, flip: 1'b0, hold: 20, gap: 3};
    vecs[2] = '{d: 8'h81, stop: 1'b1, flip: 1'b0, hold: 0,  gap: 4};
    vecs[3] = '{d: 8'h07, stop: 1'b1, flip: 1'b1, hold: 0,  gap: 2};
    vecs[4] = '{d: 8'hE1, stop: 1'b1, flip: 1'b0, hold: 0,  gap: 0};

    rst = 1'b1;
    rx  = 1'b1;
    wait_cyc(3);
    chk("rst_dv", dv, 1'b0);
    chk("rst_byte", rx_byte, 8'h00);
    chk("rst_frame_err", fe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_parity_err", pe, 1'b0);
    rst = 1'b0;
    wait_cyc(4);

    for (int i = 0; i < 5; i++) begin
      rx = 1'b1;
      wait_cyc(vecs[i].gap);
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].flip, vecs[i].hold);
    end
    rx = 1'b1;
    wait_cyc(10);

    // back-to-back 00 then FF
    seen_high = 1'b0;
    run = 0;
    maxrun = 0;
    watch = 1'b1;
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    watch = 1'b0;
    chk("b2b_busy_gap_le1", (maxrun <= 1), 1'b1);
    wait_cyc(10);

    // one-cycle glitch
    k = cyc;
    rx = 1'b0;
    wait_cyc(1);
    rx = 1'b1;
    wait_cyc(3);
    chk("glitch_busy_start", busy, 1'b1);
    wait_cyc(H + 3);
    chk("glitch_busy_idle", busy, 1'b0);
    wait_cyc(10);

    // reset during data bit 3 with the line low
    rx = 1'b0;
    wait_cyc(4 * CPB + 1);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    last_good = 8'h00;
    chk("midrst_byte", rx_byte, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    wait_cyc(20);
    chk("disarmed_busy", busy, 1'b0);
    rx = 1'b1;
    wait_cyc(5);
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    rx = 1'b1;
    wait_cyc(LAT + 10);
    chk("pending_expected", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
